uart_rx_ram_loader: RTL and testbench
=====================================

// Module: uart_rx_ram_loader
// PURPOSE
//   UART receiver that loads RAM over a serial link, the inbound counterpart of the RAM-readout UART transmitter.
//   Receives 8N1 bytes on uart_rx and packs byte pairs, high byte first, into 16-bit words.
//   Writes each word to consecutive RAM addresses starting at 0, then flags load_done.
//   Sits beside the CPU on the shared RAM port; top level muxes its address/enable/data when load is active.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//   ADDR_WIDTH    6    RAM address width
//   DATA_WIDTH    16   RAM word width; fixed at 2 bytes per word
//   NUM_WORDS     64   words to load before load_done; 1..2**ADDR_WIDTH
// PORTS
//   clk                  in   1           system clock, all logic on posedge
//   reset                in   1           synchronous, active-high
//   uart_rx              in   1           serial input, idle high, asynchronous to clk
//   enable               in   1           1 = accept new start bits
//   write_enable_to_ram  out  1           one-cycle write strobe
//   address_to_ram       out  ADDR_WIDTH  write address, valid with the strobe
//   data_to_ram          out  DATA_WIDTH  {high_byte, low_byte}, valid with the strobe
//   load_done            out  1           sticky; set when NUM_WORDS words are written
//   frame_error          out  1           sticky; set on a bad stop bit
// BEHAVIOUR
//   Reset: all outputs 0.
//   Reset internal state: FSM=IDLE, byte_phase=0, bit counter=0, baud counter=0, word counter=0.
//   Reset internal state: synchronizer flops=1.
//   Any reset cycle, including mid-byte or mid-word, discards all partial data.
//   Input path: uart_rx passes through a 2-FF synchronizer (rx_s), which adds 2 cycles of latency.
//     rx_prev holds the previous rx_s for edge detection.
//   FSM states: IDLE, START, DATA, STOP.
//   IDLE -> START
//     Condition: enable=1, load_done=0, and a falling edge (rx_prev=1, rx_s=0).
//     A line already low when enable rises is NOT a start; a high-to-low edge is needed.
//     The baud counter clears on this transition.
//   START -> DATA or IDLE
//     At baud count CLKS_PER_BIT/2-1, sample rx_s.
//     rx_s=0: go to DATA and restart the baud counter.
//     rx_s=1: glitch; return to IDLE with no error.
//   DATA: sample rx_s each time the baud count reaches CLKS_PER_BIT-1 (mid-bit).
//     Shift LSB first into the shift register.
//     Go to STOP after the 8th sample.
//   STOP -> IDLE: at mid-bit, sample rx_s, then always go to IDLE.
//     rx_s=1: byte is valid.
//     rx_s=0: set frame_error; discard the byte; byte_phase unchanged.
//   enable is checked only in IDLE; a byte in progress always completes.
//   Word assembly, on a valid byte:
//     byte_phase=0: latch the high byte; byte_phase <= 1.
//     byte_phase=1: drive data_to_ram={hi, byte} and address_to_ram=word_count.
//       Assert write_enable_to_ram for exactly 1 cycle, the cycle after the stop-bit sample.
//       Then word_count++ and byte_phase <= 0.
//   address_to_ram and data_to_ram hold their last values between strobes.
//   Completion: load_done is set in the same cycle as the strobe that writes word NUM_WORDS-1.
//     Once set, IDLE ignores all further start bits.
//     Once set, no more writes occur.
//     It clears only on reset.
//   Address wrap cannot happen: NUM_WORDS <= 2**ADDR_WIDTH and writing stops at load_done.
//   Counters:
//     baud counter width = clog2(CLKS_PER_BIT);
//     bit counter 3 bits;
//     word counter ADDR_WIDTH+1 bits.
//   Simultaneous events:
//     reset has priority over everything;
//     a falling edge in the same cycle as a stop-bit sample is missed, which is acceptable since the stop bit is high.
// TESTING (bench uses CLKS_PER_BIT=16, NUM_WORDS=4)
//   1. Reset, then send bytes 0x12,0x34.
//      -> one strobe: addr=0, data=16'h1234; load_done=0.
//   2. Send 8 bytes 0x00..0x07.
//      -> strobes addr 0..3 with data 0x0001,0x0203,0x0405,0x0607; load_done=1 with the 4th strobe.
//      Then send a 9th byte -> no strobe.
//   3. 0.25-bit low glitch on uart_rx.
//      -> no START acceptance, no strobe, frame_error=0.
//   4. Send 0xAB with stop bit 0, then 0xCD,0xEF valid.
//      -> frame_error=1; one strobe with data 16'hCDEF at addr 0.
//   5. enable=0 while sending 0x55,0x66.
//      -> no strobes; set enable=1 and send 0x77,0x88 -> strobe addr 0, data 16'h7788.
//   6. Assert reset during the DATA bits of the low byte.
//      -> all outputs 0; then 0x9A,0xBC -> strobe addr 0, data 16'h9ABC.

Source files
------------

// File: rtl/uart_rx_ram_loader.sv
// uart_rx_ram_loader: 8N1 UART receiver that packs byte pairs (high byte first)
// into words and writes them to consecutive RAM addresses from 0, then flags
// load_done. Frame errors are sticky and discard the offending byte.
module uart_rx_ram_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_WORDS    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  enable,
  output logic                  write_enable_to_ram,
  output logic [ADDR_WIDTH-1:0] address_to_ram,
  output logic [DATA_WIDTH-1:0] data_to_ram,
  output logic                  load_done,
  output logic                  frame_error
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned WCNT_W = ADDR_WIDTH + 1;
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic                r_rx_prev;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_hi;
  logic                r_byte_phase;
  logic [WCNT_W-1:0]   r_word_cnt;

  logic                w_fall;
  logic                w_baud_half;
  logic                w_baud_full;
  logic                w_baud_clr;
  logic                w_shift_en;
  logic                w_stop_sample;

  assign w_fall      = r_rx_prev & ~r_rx_s;
  assign w_baud_half = (r_baud == BAUD_HALF);
  assign w_baud_full = (r_baud == BAUD_FULL);

  // Two-flop synchronizer plus previous-sample flop for falling-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    w_state_next  = r_state;
    w_baud_clr    = 1'b0;
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !load_done && w_fall) begin
          w_state_next = S_START;
          w_baud_clr   = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_half) begin
          w_baud_clr = 1'b1;
          if (!r_rx_s) w_state_next = S_DATA;
          else         w_state_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_baud_full) begin
          w_shift_en = 1'b1;
          w_baud_clr = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_full) begin
          w_stop_sample = 1'b1;
          w_baud_clr    = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Baud and bit counters, shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      if (w_baud_clr || r_state == S_IDLE) r_baud <= '0;
      else                                  r_baud <= r_baud + BAUD_W'(1);

      if (r_state != S_DATA) r_bit_cnt <= 3'd0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // Word assembly, RAM write strobe, completion and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi                <= 8'd0;
      r_byte_phase        <= 1'b0;
      r_word_cnt          <= '0;
      write_enable_to_ram <= 1'b0;
      address_to_ram      <= '0;
      data_to_ram         <= '0;
      load_done           <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      write_enable_to_ram <= 1'b0;
      if (w_stop_sample) begin
        if (!r_rx_s) begin
          frame_error <= 1'b1;
        end else if (!load_done) begin
          if (!r_byte_phase) begin
            r_hi         <= r_shift;
            r_byte_phase <= 1'b1;
          end else begin
            write_enable_to_ram <= 1'b1;
            address_to_ram      <= r_word_cnt[ADDR_WIDTH-1:0];
            data_to_ram         <= DATA_WIDTH'({r_hi, r_shift});
            r_word_cnt          <= r_word_cnt + WCNT_W'(1);
            r_byte_phase        <= 1'b0;
            if (r_word_cnt == LAST_WORD) load_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// Testbench for uart_rx_ram_loader: table-driven byte streams plus directed
// sequences for glitch, enable gating and mid-byte reset.
module tb_uart_rx_ram_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 16;
  localparam int unsigned NW  = 4;

  logic          clk;
  logic          reset;
  logic          uart_rx;
  logic          enable;
  logic          write_enable_to_ram;
  logic [AW-1:0] address_to_ram;
  logic [DW-1:0] data_to_ram;
  logic          load_done;
  logic          frame_error;

  int total;
  int bad;

  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic          wr_ld[$];

  typedef struct packed {
    int unsigned         n_bytes;
    logic [0:8][7:0]     bytes;
    logic [8:0]          stop_ok;
    int unsigned         n_wr;
    logic [0:3][15:0]    exp_data;
    logic                exp_ld;
    logic                exp_fe;
  } vec_t;

  vec_t vecs[3];

  uart_rx_ram_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_WORDS   (NW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rx            (uart_rx),
    .enable             (enable),
    .write_enable_to_ram(write_enable_to_ram),
    .address_to_ram     (address_to_ram),
    .data_to_ram        (data_to_ram),
    .load_done          (load_done),
    .frame_error        (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle, sampled away from the active edge
  always @(negedge clk) begin
    if (write_enable_to_ram === 1'b1) begin
      wr_addr.push_back(address_to_ram);
      wr_data.push_back(data_to_ram);
      wr_ld.push_back(load_done);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset   = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    check("rst_we",   32'(write_enable_to_ram), 32'd0);
    check("rst_addr", 32'(address_to_ram),      32'd0);
    check("rst_data", 32'(data_to_ram),         32'd0);
    check("rst_done", 32'(load_done),           32'd0);
    check("rst_fe",   32'(frame_error),         32'd0);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_ld.delete();
    idle(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
    idle(4);
  endtask

  task automatic check_one_word(input string tag, input logic [15:0] exp);
    check({tag, "_count"}, 32'(wr_data.size()), 32'd1);
    if (wr_data.size() > 0) begin
      check({tag, "_addr"}, 32'(wr_addr[0]), 32'd0);
      check({tag, "_data"}, 32'(wr_data[0]), 32'(exp));
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    uart_rx = 1'b1;
    enable  = 1'b1;

    vecs[0] = '{n_bytes: 2, bytes: {8'h12, 8'h34, 56'h0}, stop_ok: 9'h1FF,
                n_wr: 1, exp_data: {16'h1234, 48'h0}, exp_ld: 1'b0, exp_fe: 1'b0};
    vecs[1] = '{n_bytes: 9,
                bytes: {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                stop_ok: 9'h1FF, n_wr: 4,
                exp_data: {16'h0001, 16'h0203, 16'h0405, 16'h0607},
                exp_ld: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{n_bytes: 3, bytes: {8'hAB, 8'hCD, 8'hEF, 48'h0}, stop_ok: 9'b1_1111_1110,
                n_wr: 1, exp_data: {16'hCDEF, 48'h0}, exp_ld: 1'b0, exp_fe: 1'b1};

    idle(3);

    // Table-driven byte streams
    for (int v = 0; v < 3; v++) begin
      reset_dut();
      for (int b = 0; b < int'(vecs[v].n_bytes); b++)
        send_byte(vecs[v].bytes[b], vecs[v].stop_ok[b]);
      idle(20);
      check($sformatf("v%0d_count", v), 32'(wr_data.size()), vecs[v].n_wr);
      for (int w = 0; w < int'(vecs[v].n_wr); w++) begin
        if (w < wr_data.size()) begin
          check($sformatf("v%0d_addr%0d", v, w), 32'(wr_addr[w]), 32'(w));
          check($sformatf("v%0d_data%0d", v, w), 32'(wr_data[w]), 32'(vecs[v].exp_data[w]));
          check($sformatf("v%0d_ld_at%0d", v, w), 32'(wr_ld[w]),
                32'((w == int'(vecs[v].n_wr) - 1) ? vecs[v].exp_ld : 1'b0));
        end
      end
      check($sformatf("v%0d_load_done", v), 32'(load_done), 32'(vecs[v].exp_ld));
      check($sformatf("v%0d_frame_err", v), 32'(frame_error), 32'(vecs[v].exp_fe));
    end

    // Quarter-bit low glitch: rejected, then a normal word still aligns
    reset_dut();
    uart_rx = 1'b0;
    idle(CPB / 4);
    uart_rx = 1'b1;
    idle(3 * CPB);
    check("glitch_count", 32'(wr_data.size()), 32'd0);
    check("glitch_fe",    32'(frame_error),    32'd0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(20);
    check_one_word("glitch_after", 16'h5AA5);

    // enable low ignores frames; enable high accepts them
    reset_dut();
    enable = 1'b0;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    idle(20);
    check("dis_count", 32'(wr_data.size()), 32'd0);
    enable = 1'b1;
    idle(4);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    idle(20);
    check_one_word("en", 16'h7788);

    // Reset during low-byte data bits discards the pending high byte too
    reset_dut();
    send_byte(8'h11, 1'b1);
    uart_rx = 1'b0;
    idle(CPB);
    uart_rx = 1'b1;
    idle(CPB / 2);
    uart_rx = 1'b0;
    idle(3 * CPB / 2);
    reset = 1'b1;
    idle(2);
    check("midrst_we",   32'(write_enable_to_ram), 32'd0);
    check("midrst_addr", 32'(address_to_ram),      32'd0);
    check("midrst_data", 32'(data_to_ram),         32'd0);
    check("midrst_done", 32'(load_done),           32'd0);
    check("midrst_fe",   32'(frame_error),         32'd0);
    uart_rx = 1'b1;
    idle(2);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_ld.delete();
    idle(2 * CPB);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    idle(20);
    check_one_word("midrst_after", 16'h9ABC);
    check("midrst_after_fe", 32'(frame_error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
